// File: rtl/ecc_params_pkg.sv
// Shared P-384 constants and types for the ECC datapath.
// Both moduli live here so every Montgomery stage agrees on the same values.
package ecc_params_pkg;

    localparam int REG_SIZE   = 384;
    localparam int MULT_RADIX = 48;
    localparam int NUM_ITER   = REG_SIZE / MULT_RADIX;
    localparam int ACC_W      = REG_SIZE + MULT_RADIX + 1;
    localparam int CNT_W      = $clog2(NUM_ITER);

    localparam logic [REG_SIZE-1:0] PRIME =
        384'hfffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffeffffffff0000000000000000ffffffff;
    localparam logic [REG_SIZE-1:0] GROUP_ORDER =
        384'hffffffffffffffffffffffffffffffffffffffffffffffffc7634d81f4372ddf581a0db248b0a77aecec196accc52973;

    // -M^-1 mod 2^64; consumers keep only the low MULT_RADIX bits.
    localparam logic [63:0] PRIME_mu       = 64'h0000000100000001;
    localparam logic [63:0] GROUP_ORDER_mu = 64'h6ed46089e88fdc45;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_SUB,
        ST_DONE
    } exit_state_e;

    typedef logic [ACC_W-1:0] acc_t;

endpackage

// File: rtl/ecc_mont_redc_step.sv
// One word-serial Montgomery reduction step: clears the low digit of T
// by adding a multiple of MOD, then drops that digit.
module ecc_mont_redc_step
    import ecc_params_pkg::*;
(
    input  logic [ACC_W-1:0]      t_in,
    input  logic [REG_SIZE-1:0]   mod,
    input  logic [MULT_RADIX-1:0] mu,
    output logic [ACC_W-1:0]      t_out
);

    logic [MULT_RADIX-1:0]          m;
    logic [REG_SIZE+MULT_RADIX-1:0] prod;
    logic [ACC_W:0]                 sum;

    assign m     = MULT_RADIX'(t_in[MULT_RADIX-1:0] * mu);
    assign prod  = {{REG_SIZE{1'b0}}, m} * {{MULT_RADIX{1'b0}}, mod};
    // Full-width sum so the carry into the top bit survives the shift.
    assign sum   = {1'b0, t_in} + {2'b00, prod};
    assign t_out = ACC_W'(sum >> MULT_RADIX);

endmodule

// File: rtl/ecc_mont_exit.sv
// Montgomery-domain exit: out = in * 2^-REG_SIZE mod (PRIME | GROUP_ORDER),
// one digit per cycle followed by a single conditional subtract.
module ecc_mont_exit
    import ecc_params_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                zeroize,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sel_order,
    input  logic [REG_SIZE-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [REG_SIZE-1:0] out_data
);

    exit_state_e           state;
    acc_t                  t_q;
    acc_t                  t_next;
    logic [REG_SIZE-1:0]   mod_q;
    logic [MULT_RADIX-1:0] mu_q;
    logic [CNT_W-1:0]      cnt;

    ecc_mont_redc_step u_step (
        .t_in  (t_q),
        .mod   (mod_q),
        .mu    (mu_q),
        .t_out (t_next)
    );

    always_ff @(posedge clk) begin
        if (rst || zeroize) begin
            state     <= ST_IDLE;
            t_q       <= '0;
            mod_q     <= '0;
            mu_q      <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        t_q      <= ACC_W'(in_data);
                        mod_q    <= in_sel_order ? GROUP_ORDER : PRIME;
                        mu_q     <= in_sel_order ? GROUP_ORDER_mu[MULT_RADIX-1:0]
                                                 : PRIME_mu[MULT_RADIX-1:0];
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    t_q <= t_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(NUM_ITER - 1))
                        state <= ST_SUB;
                end
                ST_SUB: begin
                    // T < 2*MOD here, so one subtract fully reduces.
                    out_data  <= (t_q >= ACC_W'(mod_q)) ? REG_SIZE'(t_q - ACC_W'(mod_q))
                                                        : t_q[REG_SIZE-1:0];
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    // Returning through IDLE keeps accept off the drain cycle.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_mont_exit.sv
// Randomized check of ecc_mont_exit against a modular-halving reference.
module tb_ecc_mont_exit;
    import ecc_params_pkg::*;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                zeroize = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic                in_sel_order = 1'b0;
    logic [REG_SIZE-1:0] in_data = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [REG_SIZE-1:0] out_data;

    int n_cmp = 0;
    int n_bad = 0;

    ecc_mont_exit dut (
        .clk          (clk),
        .rst          (rst),
        .zeroize      (zeroize),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sel_order (in_sel_order),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [383:0] got, input logic [383:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // x * 2^-384 mod m by halving modulo m, 384 times.
    function automatic logic [383:0] ref_exit(input logic [383:0] x, input logic [383:0] m);
        logic [383:0] r;
        logic [385:0] t;
        r = x % m;
        t = {2'b00, r};
        for (int i = 0; i < 384; i++) begin
            if (t[0]) t = t + {2'b00, m};
            t = t >> 1;
        end
        return t[383:0];
    endfunction

    function automatic logic [383:0] to_mont(input logic [383:0] x, input logic [383:0] m);
        logic [1023:0] big;
        big = ({640'b0, x} << 384) % {640'b0, m};
        return big[383:0];
    endfunction

    function automatic logic [383:0] rnd384();
        logic [383:0] v;
        for (int i = 0; i < 12; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic send(input logic [383:0] d, input logic sel);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data = d;
        in_sel_order = sel;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 384'(in_ready), 384'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data = rnd384();
        in_sel_order = ~sel;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 50);
        chk("out_valid", 384'(out_valid), 384'(1));
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic convert(input logic [383:0] d, input logic sel, output logic [383:0] res, output int lat);
        send(d, sel);
        wait_done(lat);
        res = out_data;
        ack();
    endtask

    logic [383:0] gx, one_p, one_q, r2_p, res, m, cap, x;
    int lat;

    initial begin
        gx    = 384'haa87ca22be8b05378eb1c71ef320ad746e1d3b628ba79b9859f741e082542a385502f25dbf55296c3a545e3872760ab7;
        one_p = to_mont(384'd1, PRIME);
        one_q = to_mont(384'd1, GROUP_ORDER);
        r2_p  = to_mont(one_p, PRIME);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 384'(in_ready), 384'(1));
        chk("rst_out_valid", 384'(out_valid), 384'(0));
        chk("rst_out_data", out_data, 384'(0));

        convert(one_p, 1'b0, res, lat);
        chk("one_p", res, 384'(1));
        chk("latency", 384'(lat), 384'(10));
        convert(to_mont(gx, PRIME), 1'b0, res, lat);
        chk("gx", res, gx);
        convert(r2_p, 1'b0, res, lat);
        chk("r2_p", res, one_p);
        convert(one_q, 1'b1, res, lat);
        chk("one_q", res, 384'(1));
        convert(384'd0, 1'b0, res, lat);
        chk("zero", res, 384'(0));
        convert(GROUP_ORDER, 1'b1, res, lat);
        chk("n_in", res, 384'(0));
        convert(PRIME, 1'b0, res, lat);
        chk("p_in", res, 384'(0));
        for (int s = 0; s < 2; s++) begin
            m = s ? GROUP_ORDER : PRIME;
            convert({384{1'b1}}, s[0], res, lat);
            chk("ones", res, ref_exit({384{1'b1}}, m));
            chk("ones_lt", 384'(res < m), 384'(1));
        end

        for (int i = 0; i < 40; i++) begin
            x = rnd384();
            m = i[0] ? GROUP_ORDER : PRIME;
            convert(x, i[0], res, lat);
            chk("rand", res, ref_exit(x, m));
            chk("rand_lt", 384'(res < m), 384'(1));
            chk("rand_lat", 384'(lat), 384'(10));
        end

        // Back-pressure in DONE, then ack overlapping a new request.
        send(to_mont(gx, PRIME), 1'b0);
        wait_done(lat);
        cap = out_data;
        chk("stall_data0", cap, gx);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_data", out_data, cap);
            chk("stall_valid", 384'(out_valid), 384'(1));
            chk("stall_ready", 384'(in_ready), 384'(0));
        end
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = one_p;
        in_sel_order = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        chk("drain_valid", 384'(out_valid), 384'(0));
        chk("drain_ready", 384'(in_ready), 384'(1));
        @(negedge clk);
        in_valid = 1'b0;
        chk("next_accept", 384'(in_ready), 384'(0));
        wait_done(lat);
        chk("next_one", out_data, 384'(1));
        ack();

        // Reset in the middle of RUN.
        send(rnd384(), 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_ready", 384'(in_ready), 384'(1));
        chk("mid_rst_valid", 384'(out_valid), 384'(0));
        chk("mid_rst_data", out_data, 384'(0));
        repeat (12) @(negedge clk);
        chk("mid_rst_quiet", 384'(out_valid), 384'(0));

        // Zeroize while a result waits in DONE.
        send(to_mont(gx, PRIME), 1'b0);
        wait_done(lat);
        zeroize = 1'b1;
        @(negedge clk);
        zeroize = 1'b0;
        chk("zz_ready", 384'(in_ready), 384'(1));
        chk("zz_valid", 384'(out_valid), 384'(0));
        chk("zz_data", out_data, 384'(0));
        convert(one_p, 1'b0, res, lat);
        chk("zz_one_p", res, 384'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
